serial_addsub: RTL and testbench

Parametrised bit-serial adder/subtractor built around a single registered full-adder cell. It processes one bit per clock, LSB first, so a WIDTH-bit add or subtract completes in WIDTH cycles with constant area. It is the multi-bit, sequential successor to the single-bit combinational full adder. Datapath blocks use it when area matters more than latency, and it communicates through a start/busy/done handshake.

---
 rtl/serial_addsub.sv | 127 ++++++++++++
 tb/tb_serial_addsub.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - bit-serial adder/subtractor, one bit per clock, LSB first
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  // Counter must hold values up to WIDTH-1 without wrapping.
  localparam int CW = (WIDTH < 2) ? 1 : $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             w_accept;
  logic             w_last;

  // The A register doubles as the working result register: each consumed
  // operand bit leaves at the LSB while the new sum bit enters at the MSB,
  // so after WIDTH shifts it holds the complete result.
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] w_a_next;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             w_s;
  logic             w_carry_next;

  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_c_out;
  logic             r_overflow;

  // Single full-adder cell on the current LSBs.
  assign w_s          = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_carry_next = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));

  generate
    if (WIDTH == 1) begin : g_w1
      assign w_a_next = w_s;
    end else begin : g_wn
      assign w_a_next = {w_s, r_a[WIDTH-1:1]};
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic plus accept/last-bit strobes.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (r_cnt == LAST) begin
          w_last       = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Operand load, per-bit shift, and result capture on the final bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a        <= '0;
      r_b        <= '0;
      r_carry    <= 1'b0;
      r_cnt      <= '0;
      r_done     <= 1'b0;
      r_sum      <= '0;
      r_c_out    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        r_a     <= a;
        r_b     <= b ^ {WIDTH{sub}};
        r_carry <= sub;
        r_cnt   <= '0;
      end else if (r_state == RUN) begin
        r_a     <= w_a_next;
        r_b     <= r_b >> 1;
        r_carry <= w_carry_next;
        r_cnt   <= r_cnt + 1'b1;
        if (w_last) begin
          // r_carry is the carry into the MSB at this point.
          r_sum      <= w_a_next;
          r_c_out    <= w_carry_next;
          r_overflow <= r_carry ^ w_carry_next;
        end
      end
    end
  end

  assign busy     = (r_state == RUN);
  assign done     = r_done;
  assign sum      = r_sum;
  assign c_out    = r_c_out;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_serial_addsub.sv
// tb/tb_serial_addsub.sv - directed self-checking bench for serial_addsub (WIDTH=8 and WIDTH=1)
module tb_serial_addsub;

  logic       clk;
  logic       rst8, start8, sub8;
  logic [7:0] a8, b8;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;

  logic       rst1, start1, sub1;
  logic [0:0] a1, b1;
  logic       busy1, done1, cout1, ovf1;
  logic [0:0] sum1;

  int n_checks;
  int n_errors;

  serial_addsub #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(rst8), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .c_out(cout8), .overflow(ovf8)
  );

  serial_addsub #(.WIDTH(1)) u_dut1 (
    .clk(clk), .reset(rst1), .start(start1), .sub(sub1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .sum(sum1), .c_out(cout1), .overflow(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; start is seen by the following posedge. Returns at the
  // negedge after the accept edge.
  task automatic launch8(input logic s, input logic [7:0] x, input logic [7:0] y);
    start8 = 1'b1; sub8 = s; a8 = x; b8 = y;
    @(negedge clk);
    start8 = 1'b0;
  endtask

  // Waits for done, verifying busy and the held previous result meanwhile.
  // lat counts edges since the accept edge; returns at the done negedge.
  task automatic wait_done8(input int lat0, input logic [7:0] prev, output int lat);
    lat = lat0;
    while (!done8 && lat < 20) begin
      check("busy8_run", busy8, 1'b1);
      check("sum8_hold", sum8, prev);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic expect8(input string tag, input int lat, input logic [7:0] s,
                         input logic c, input logic v);
    check({tag, "_done"}, done8, 1'b1);
    check({tag, "_lat"}, lat, 8);
    check({tag, "_busy"}, busy8, 1'b0);
    check({tag, "_sum"}, sum8, s);
    check({tag, "_cout"}, cout8, c);
    check({tag, "_ovf"}, ovf8, v);
  endtask

  task automatic op1(input string tag, input logic s, input logic x, input logic y,
                     input logic es, input logic ec, input logic ev);
    int lat;
    start1 = 1'b1; sub1 = s; a1 = x; b1 = y;
    @(negedge clk);
    start1 = 1'b0;
    lat = 0;
    while (!done1 && lat < 10) begin
      check({tag, "_busy"}, busy1, 1'b1);
      @(negedge clk);
      lat++;
    end
    check({tag, "_done"}, done1, 1'b1);
    check({tag, "_lat"}, lat, 1);
    check({tag, "_sum"}, sum1, es);
    check({tag, "_cout"}, cout1, ec);
    check({tag, "_ovf"}, ovf1, ev);
    @(negedge clk);
    check({tag, "_pulse"}, done1, 1'b0);
  endtask

  initial begin
    int lat;
    int pulses;
    n_checks = 0;
    n_errors = 0;
    rst8 = 1'b1; start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
    rst1 = 1'b1; start1 = 1'b0; sub1 = 1'b0; a1 = '0; b1 = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy8, 1'b0);
    check("rst_done", done8, 1'b0);
    check("rst_sum", sum8, 8'h00);
    check("rst_cout", cout8, 1'b0);
    check("rst_ovf", ovf8, 1'b0);
    check("rst1_busy", busy1, 1'b0);
    rst8 = 1'b0; rst1 = 1'b0;
    @(negedge clk);

    // 0x5A + 0x33 = 0x8D, signed overflow
    launch8(1'b0, 8'h5A, 8'h33);
    wait_done8(0, 8'h00, lat);
    expect8("add1", lat, 8'h8D, 1'b0, 1'b1);
    @(negedge clk);
    check("add1_pulse", done8, 1'b0);

    // 0xFF + 0x01 wraps to 0 with carry; 0x8D holds until completion
    launch8(1'b0, 8'hFF, 8'h01);
    wait_done8(0, 8'h8D, lat);
    expect8("add2", lat, 8'h00, 1'b1, 1'b0);
    @(negedge clk);

    // 0x10 - 0x20 = 0xF0 with borrow, then back-to-back 0x80 - 0x01
    launch8(1'b1, 8'h10, 8'h20);
    wait_done8(0, 8'h00, lat);
    expect8("sub1", lat, 8'hF0, 1'b0, 1'b0);
    launch8(1'b1, 8'h80, 8'h01);
    wait_done8(0, 8'hF0, lat);
    expect8("sub2", lat, 8'h7F, 1'b1, 1'b1);
    @(negedge clk);

    // start re-asserted during RUN with other operands must be ignored
    launch8(1'b0, 8'h12, 8'h34);
    start8 = 1'b1; sub8 = 1'b1; a8 = 8'hFF; b8 = 8'h0F;
    @(negedge clk);
    @(negedge clk);
    start8 = 1'b0;
    wait_done8(2, 8'h7F, lat);
    expect8("midrun", lat, 8'h46, 1'b0, 1'b0);
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) pulses++;
    end
    check("midrun_pulses", pulses, 0);
    check("midrun_idle", busy8, 1'b0);

    // reset in the fourth RUN cycle aborts and clears the previous 0x46
    launch8(1'b0, 8'hAA, 8'h55);
    repeat (3) @(negedge clk);
    rst8 = 1'b1;
    @(negedge clk);
    rst8 = 1'b0;
    check("abort_busy", busy8, 1'b0);
    check("abort_done", done8, 1'b0);
    check("abort_sum", sum8, 8'h00);
    check("abort_cout", cout8, 1'b0);
    check("abort_ovf", ovf8, 1'b0);
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) pulses++;
    end
    check("abort_pulses", pulses, 0);

    // reset and start on the same edge: operation must not be accepted
    rst8 = 1'b1; start8 = 1'b1; a8 = 8'h01; b8 = 8'h02; sub8 = 1'b0;
    @(negedge clk);
    rst8 = 1'b0; start8 = 1'b0;
    check("rst_start_busy", busy8, 1'b0);

    launch8(1'b0, 8'h01, 8'h01);
    wait_done8(0, 8'h00, lat);
    expect8("post", lat, 8'h02, 1'b0, 1'b0);
    @(negedge clk);

    // single-bit instance
    op1("w1_add", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    op1("w1_sub", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
